// File: rtl/wtm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : wtm_pkg                                                     |
// | Brief  : Shared state encoding, default width and clog2 helper.      |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
package wtm_pkg;

    localparam int DEFAULT_W = 8;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SETTLE = 2'd1;
    localparam state_t ST_RESP   = 2'd2;

    function automatic int wtm_clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : rr_pick                                                     |
// | Brief  : Combinational round-robin picker: first set request at or   |
// |          after the pointer, wrapping past the top index.             |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module rr_pick
    import wtm_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_win_onehot,
    output logic [IDX_W-1:0] o_win_idx,
    output logic             o_any
);

    int w_j;

    // Scan offsets from highest to lowest so the nearest hit to the pointer wins.
    always_comb begin
        o_win_idx = '0;
        w_j       = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_j = int'(i_ptr) + k;
            if (w_j >= N_REQ) begin
                w_j = w_j - N_REQ;
            end
            if (i_req[w_j]) begin
                o_win_idx = IDX_W'(w_j);
            end
        end
    end

    assign o_any        = |i_req;
    assign o_win_onehot = o_any ? (N_REQ'(1) << o_win_idx) : '0;

endmodule
`default_nettype wire

// File: rtl/wallace_mult_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : wallace_mult_arbiter                                        |
// | Brief  : Round-robin sharing of one external combinational multiplier|
// |          among N_REQ requesters, with valid/ack product return.      |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module wallace_mult_arbiter
    import wtm_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int W             = DEFAULT_W,
    parameter int SETTLE_CYCLES = 2,
    parameter int ID_W          = wtm_clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ*W-1:0]   a_in,
    input  logic [N_REQ*W-1:0]   b_in,
    output logic [N_REQ-1:0]     gnt,
    output logic [2*W-1:0]       prod_out,
    output logic [ID_W-1:0]      prod_id,
    output logic                 prod_valid,
    input  logic                 prod_ack,
    output logic [W-1:0]         mul_a,
    output logic [W-1:0]         mul_b,
    input  logic [2*W-1:0]       mul_p
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? wtm_clog2(SETTLE_CYCLES) : 1;

    state_t             r_state_q, w_state_d;
    logic [CNT_W-1:0]   r_cnt_q, w_cnt_d;
    logic [ID_W-1:0]    r_ptr_q, w_ptr_d;
    logic [N_REQ-1:0]   r_gnt_q, w_gnt_d;
    logic [2*W-1:0]     r_prod_out_q, w_prod_out_d;
    logic [ID_W-1:0]    r_prod_id_q, w_prod_id_d;
    logic               r_prod_valid_q, w_prod_valid_d;
    logic [W-1:0]       r_mul_a_q, w_mul_a_d;
    logic [W-1:0]       r_mul_b_q, w_mul_b_d;

    logic [N_REQ-1:0]   w_pick_onehot;
    logic [ID_W-1:0]    w_pick_idx;
    logic               w_pick_any;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (ID_W)
    ) u_rr_pick (
        .i_req        (req),
        .i_ptr        (r_ptr_q),
        .o_win_onehot (w_pick_onehot),
        .o_win_idx    (w_pick_idx),
        .o_any        (w_pick_any)
    );

    always_comb begin
        w_state_d      = r_state_q;
        w_cnt_d        = r_cnt_q;
        w_ptr_d        = r_ptr_q;
        w_gnt_d        = '0;
        w_prod_out_d   = r_prod_out_q;
        w_prod_id_d    = r_prod_id_q;
        w_prod_valid_d = r_prod_valid_q;
        w_mul_a_d      = r_mul_a_q;
        w_mul_b_d      = r_mul_b_q;
        case (r_state_q)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_mul_a_d   = a_in[int'(w_pick_idx)*W +: W];
                    w_mul_b_d   = b_in[int'(w_pick_idx)*W +: W];
                    w_gnt_d     = w_pick_onehot;
                    w_prod_id_d = w_pick_idx;
                    w_cnt_d     = CNT_W'(SETTLE_CYCLES - 1);
                    w_state_d   = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // Operands have been stable on the multiplier for SETTLE_CYCLES edges at capture.
                if (r_cnt_q != '0) begin
                    w_cnt_d = r_cnt_q - CNT_W'(1);
                end else begin
                    w_prod_out_d   = mul_p;
                    w_prod_valid_d = 1'b1;
                    w_state_d      = ST_RESP;
                end
            end
            ST_RESP: begin
                if (prod_ack) begin
                    w_prod_valid_d = 1'b0;
                    w_ptr_d        = (r_prod_id_q == ID_W'(N_REQ - 1)) ? '0
                                                                       : r_prod_id_q + ID_W'(1);
                    w_state_d      = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= ST_IDLE;
            r_cnt_q        <= '0;
            r_ptr_q        <= '0;
            r_gnt_q        <= '0;
            r_prod_out_q   <= '0;
            r_prod_id_q    <= '0;
            r_prod_valid_q <= 1'b0;
            r_mul_a_q      <= '0;
            r_mul_b_q      <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_cnt_q        <= w_cnt_d;
            r_ptr_q        <= w_ptr_d;
            r_gnt_q        <= w_gnt_d;
            r_prod_out_q   <= w_prod_out_d;
            r_prod_id_q    <= w_prod_id_d;
            r_prod_valid_q <= w_prod_valid_d;
            r_mul_a_q      <= w_mul_a_d;
            r_mul_b_q      <= w_mul_b_d;
        end
    end

    assign gnt        = r_gnt_q;
    assign prod_out   = r_prod_out_q;
    assign prod_id    = r_prod_id_q;
    assign prod_valid = r_prod_valid_q;
    assign mul_a      = r_mul_a_q;
    assign mul_b      = r_mul_b_q;

endmodule
`default_nettype wire

// File: tb/tb_wallace_mult_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_wallace_mult_arbiter                                     |
// | Brief  : Directed plus randomized bench with a transaction-level     |
// |          reference model and per-cycle output comparison.           |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_wallace_mult_arbiter;

    localparam int N = 4;
    localparam int W = 8;
    localparam int S = 2;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req;
    logic [N*W-1:0]   a_in;
    logic [N*W-1:0]   b_in;
    logic [N-1:0]     gnt;
    logic [2*W-1:0]   prod_out;
    logic [1:0]       prod_id;
    logic             prod_valid;
    logic             prod_ack;
    logic [W-1:0]     mul_a;
    logic [W-1:0]     mul_b;
    logic [2*W-1:0]   mul_p;

    int n_cmp = 0;
    int n_err = 0;

    wallace_mult_arbiter #(
        .N_REQ         (N),
        .W             (W),
        .SETTLE_CYCLES (S)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .a_in       (a_in),
        .b_in       (b_in),
        .gnt        (gnt),
        .prod_out   (prod_out),
        .prod_id    (prod_id),
        .prod_valid (prod_valid),
        .prod_ack   (prod_ack),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_p      (mul_p)
    );

    // Reference multiplier standing in for the external Wallace tree.
    assign mul_p = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one op in flight, aged in edges since grant.
    bit              m_busy, m_valid;
    int              m_ptr, m_win, m_age;
    logic [W-1:0]    m_a, m_b;
    logic [2*W-1:0]  m_prod;
    int              m_id;
    logic [N-1:0]    m_gnt;

    always @(posedge clk) begin
        m_gnt = '0;
        if (rst) begin
            m_busy = 0; m_valid = 0; m_ptr = 0; m_age = 0; m_win = 0;
            m_a = '0; m_b = '0; m_prod = '0; m_id = 0;
        end else if (!m_busy) begin
            if (req != '0) begin
                for (int k = N - 1; k >= 0; k--)
                    if (req[(m_ptr + k) % N]) m_win = (m_ptr + k) % N;
                m_busy = 1;
                m_age  = 0;
                m_a    = a_in[m_win*W +: W];
                m_b    = b_in[m_win*W +: W];
                m_id   = m_win;
                m_gnt[m_win] = 1'b1;
            end
        end else if (m_valid) begin
            if (prod_ack) begin
                m_valid = 0;
                m_busy  = 0;
                m_ptr   = (m_win + 1) % N;
            end
        end else begin
            m_age++;
            if (m_age == S) begin
                m_valid = 1;
                m_prod  = 16'(int'(m_a) * int'(m_b));
            end
        end
    end

    always @(negedge clk) begin
        chk("gnt", 64'(gnt), 64'(m_gnt));
        chk("prod_valid", 64'(prod_valid), 64'(m_valid));
        chk("prod_out", 64'(prod_out), 64'(m_prod));
        chk("prod_id", 64'(prod_id), 64'(m_id));
        chk("mul_a", 64'(mul_a), 64'(m_a));
        chk("mul_b", 64'(mul_b), 64'(m_b));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        a_in[i*W +: W] = W'(a);
        b_in[i*W +: W] = W'(b);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!prod_valid && n < 20) begin
            step();
            n++;
        end
        chk("valid_timeout", 64'(prod_valid), 64'd1);
    endtask

    function automatic int oh2idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int order[$];
        int exp_order[5];
        int g2;
        rst = 1'b1; req = '0; a_in = '0; b_in = '0; prod_ack = 1'b0;
        step(); step();
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_valid", 64'(prod_valid), 64'd0);
        rst = 1'b0;
        step();

        // Single request from requester 1.
        set_op(1, 13, 11);
        req = 4'b0010;
        step();
        chk("t1_gnt", 64'(gnt), 64'b0010);
        req = '0;
        step();
        chk("t1_not_yet", 64'(prod_valid), 64'd0);
        step();
        chk("t1_valid", 64'(prod_valid), 64'd1);
        chk("t1_prod", 64'(prod_out), 64'd143);
        chk("t1_id", 64'(prod_id), 64'd1);
        prod_ack = 1'b1;
        step();
        prod_ack = 1'b0;
        chk("t1_drop", 64'(prod_valid), 64'd0);

        // Full-width product.
        set_op(0, 255, 255);
        req = 4'b0001;
        step();
        req = '0;
        wait_valid();
        chk("t3_prod", 64'(prod_out), 64'hFE01);
        prod_ack = 1'b1; step(); prod_ack = 1'b0;

        // Rotation from a fresh pointer.
        rst = 1'b1; step(); rst = 1'b0;
        req = 4'b1111; prod_ack = 1'b1;
        for (int c = 0; c < 40 && order.size() < 5; c++) begin
            step();
            if (gnt != '0) order.push_back(oh2idx(gnt));
        end
        req = '0;
        exp_order = '{0, 1, 2, 3, 0};
        chk("t2_count", 64'(order.size()), 64'd5);
        for (int i = 0; i < 5 && i < order.size(); i++)
            chk("t2_order", 64'(order[i]), 64'(exp_order[i]));
        repeat (6) step();
        prod_ack = 1'b0;

        // Withheld ack; new request waits for one IDLE cycle.
        set_op(2, 7, 9);
        req = 4'b0100;
        step();
        chk("t4_gnt", 64'(gnt), 64'b0100);
        req = '0;
        wait_valid();
        chk("t4_prod", 64'(prod_out), 64'd63);
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                set_op(1, 3, 5);
                req = 4'b0010;
            end
            step();
            chk("t4_hold_valid", 64'(prod_valid), 64'd1);
            chk("t4_hold_prod", 64'(prod_out), 64'd63);
            chk("t4_hold_mula", 64'(mul_a), 64'd7);
        end
        prod_ack = 1'b1;
        step();
        prod_ack = 1'b0;
        chk("t4_ack_valid", 64'(prod_valid), 64'd0);
        chk("t4_idle_gnt", 64'(gnt), 64'd0);
        step();
        chk("t4_next_gnt", 64'(gnt), 64'b0010);
        req = '0;
        wait_valid();
        chk("t4_prod2", 64'(prod_out), 64'd15);
        prod_ack = 1'b1; step(); prod_ack = 1'b0;

        // Reset mid-SETTLE drops the op and restarts the pointer.
        set_op(3, 20, 30);
        req = 4'b1000;
        step();
        chk("t5_gnt", 64'(gnt), 64'b1000);
        req = '0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_valid", 64'(prod_valid), 64'd0);
        chk("t5_mula", 64'(mul_a), 64'd0);
        chk("t5_prod", 64'(prod_out), 64'd0);
        req = 4'b0101;
        step();
        chk("t5_gnt_after", 64'(gnt), 64'b0001);
        req = '0;
        wait_valid();
        chk("t5_prod_after", 64'(prod_out), 64'hFE01);

        // Request pulsed only while a result is pending.
        g2 = 0;
        req = 4'b0100;
        step(); step();
        req = '0;
        prod_ack = 1'b1;
        step();
        prod_ack = 1'b0;
        repeat (6) begin
            step();
            if (gnt[2]) g2++;
        end
        chk("t6_never_granted", 64'(g2), 64'd0);

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (gnt[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i] && ($urandom % 4) == 0) begin
                    set_op(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
                    req[i] = 1'b1;
                end
            end
            prod_ack = (($urandom % 3) == 0);
            if (c % 97 == 50) rst = 1'b1;
            else rst = 1'b0;
        end
        rst = 1'b0;
        req = '0;
        prod_ack = 1'b1;
        repeat (10) step();
        prod_ack = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
